uc_arbiter: RTL
===============

Name: uc_arbiter

Overview:
- Producer side of the unit-clause queue interface. Collects implied unit clauses from NUM_ENG process engines and selects one per cycle by round-robin.
- Filters each selected literal against a per-variable assignment table: duplicates are dropped, conflicts are flagged, and new literals are pushed.
- New literals are broadcast to all NUM_Q unit-clause queues with a single push strobe.
- A sweep FSM clears the assignment table between solver decisions.

Parameters:
- NUM_ENG, 4, number of engine request ports.
- NUM_Q, 4, number of unit-clause queues fed in lockstep.
- UC_LENGTH, 512, literal code space. LIT_W = $clog2(UC_LENGTH) = 9. VAR_W = LIT_W-1 = 8. Table depth 2^VAR_W = 256.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- eng_valid  in  NUM_ENG  per-engine request valid.
- eng_lit  in  NUM_ENG x LIT_W  literal: bit LIT_W-1 = polarity (1 = negated), bits VAR_W-1:0 = variable index.
- eng_ready  out  NUM_ENG  one-hot grant. A request is consumed when eng_valid[i] && eng_ready[i].
- ucq_full  in  NUM_Q  full flags from the queues.
- ucq_push  out  1  push strobe to every queue.
- uca2ucq  out  LIT_W  literal pushed.
- clear_req  in  1  start a table clear.
- clear_done  out  1  one-cycle pulse when the clear sweep ends.
- conflict  out  1  sticky conflict flag.
- conflict_lit  out  LIT_W  the literal that caused the conflict.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - FSM goes to RUN; rr pointer = 0; table all unassigned.
  - conflict = 0, conflict_lit = 0, clear_done = 0.
  - ucq_push = 0, eng_ready = 0, uca2ucq = 0.
- Table: each entry is {assigned, value}, 2 bits per variable, held in flops.
- FSM states:
  - RUN: normal arbitration.
  - CONFL: entered on a conflict; holds until clear_req.
  - CLEAR: sweeps the table.
- Arbitration (RUN only):
  - Grant only when no ucq_full bit is set (all queues have space).
  - Grant goes to the first requester at or after the rr pointer, searching upward with wrap.
  - On a grant, the pointer moves to granted index + 1 (mod NUM_ENG). Otherwise it holds.
  - eng_ready is combinational, at most one bit set, and 0 whenever any queue is full.
- Filter (same cycle as the grant, reads the registered table state):
  - Unassigned variable: ucq_push = 1 and uca2ucq = literal, combinationally in the same cycle (zero latency). Entry is written {1, polarity} at the clock edge.
  - Assigned with equal value: request consumed, ucq_push = 0 (duplicate dropped).
  - Assigned with opposite value: request consumed, no push. conflict is set and conflict_lit latched at the edge; next state is CONFL.
- CONFL: eng_ready = 0 and ucq_push = 0. conflict stays at 1 until the next clear_req is accepted.
- CLEAR:
  - clear_req is accepted in RUN or CONFL. At that edge conflict is cleared, and the sweep counter starts at 0 and then runs 0 to 255.
  - One entry is zeroed per cycle. No grants during CLEAR.
  - At counter = 255: clear_done pulses high for that cycle, and the next state is RUN.
  - Total duration is 256 cycles.
  - clear_req asserted while already in CLEAR is ignored.
- Simultaneous events:
  - clear_req together with a valid request in RUN: clear wins and no grant is issued that cycle.
  - The table write and the clear start never coincide.
- Two engines proposing the same variable in one cycle: only one is granted. The other is filtered next cycle against the updated table.
- Reset mid-CLEAR or mid-CONFL returns the block to reset state immediately; the table is fully cleared by rst.

Optional Feature:
- Macro: UCA_STATS_EN.
- Defined: adds outputs stat_push, stat_dup and stat_conf, each 32 bits.
  - They count pushes, dropped duplicates and conflicts respectively.
  - All reset to 0, are not cleared by clear_req, and saturate at 2^32-1.
- Undefined: none of these ports or counters exist; all other behaviour is identical.

Test Plan:
- Round-robin: after reset, all 4 engines valid with literals 0x003, 0x005, 0x007, 0x009 and queues not full -> grants on 4 consecutive cycles to eng 0, 1, 2, 3. ucq_push = 1 each cycle with uca2ucq = 0x003, 0x005, 0x007, 0x009. Then a second request from eng 0 for var 0x0B (lit 0x00B), with eng 1-3 valid on fresh variables -> that cycle's grant goes to eng 0 (pointer wrapped).
- Duplicate: push 0x012, then eng 2 sends 0x012 -> eng_ready[2] = 1, ucq_push = 0. With UCA_STATS_EN, stat_dup = 1.
- Conflict: push 0x012, then send 0x112 -> no push; next cycle conflict = 1 and conflict_lit = 0x112. A following valid 0x020 gets eng_ready = 0 until clear.
- Backpressure: ucq_full = 4'b0100 with eng 1 valid -> eng_ready = 0 and rr pointer unchanged. Release ucq_full -> eng 1 granted the same cycle.
- Clear: in CONFL, pulse clear_req -> conflict = 0 next cycle. clear_done pulses exactly 256 cycles after the clear_req edge. Afterwards 0x112 is pushed as a new literal.
- Reset mid-clear: assert rst at sweep count 100 -> all outputs at reset values. Previously assigned 0x012 is accepted and pushed after reset.

Source files
------------

// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: round-robin engine grant, assignment-table filter, sweep clear.
// Optional UCA_STATS_EN adds saturating push/duplicate/conflict counters.
module uc_arbiter #(
  parameter int NUM_ENG   = 4,
  parameter int NUM_Q     = 4,
  parameter int UC_LENGTH = 512,
  parameter int LIT_W     = $clog2(UC_LENGTH),
  parameter int VAR_W     = LIT_W - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_ENG-1:0]       eng_valid,
  input  logic [NUM_ENG*LIT_W-1:0] eng_lit,
  output logic [NUM_ENG-1:0]       eng_ready,
  input  logic [NUM_Q-1:0]         ucq_full,
  output logic                     ucq_push,
  output logic [LIT_W-1:0]         uca2ucq,
  input  logic                     clear_req,
  output logic                     clear_done,
`ifdef UCA_STATS_EN
  output logic [31:0]              stat_push,
  output logic [31:0]              stat_dup,
  output logic [31:0]              stat_conf,
`endif
  output logic                     conflict,
  output logic [LIT_W-1:0]         conflict_lit
);

  localparam int TBL_D = 1 << VAR_W;
  localparam int IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_CONFL = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [VAR_W-1:0] cnt_q;
  logic             conflict_q;
  logic [LIT_W-1:0] clit_q;
  logic [1:0]       tbl_q [TBL_D];

  logic             found;
  logic [IDX_W-1:0] gidx;
  logic             grant;
  logic [LIT_W-1:0] sel_lit;
  logic [VAR_W-1:0] sel_var;
  logic             sel_pol;
  logic [1:0]       entry;
  logic             do_conf;
  logic             do_dup;
  logic             clr_start;
  logic             sweep_end;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (!found && eng_valid[(int'(rr_q) + i) % NUM_ENG]) begin
        found = 1'b1;
        gidx  = IDX_W'((int'(rr_q) + i) % NUM_ENG);
      end
    end
  end

  // Clear request pre-empts any grant in the same cycle.
  assign grant = !rst && (state_q == S_RUN) && !clear_req
               && !(|ucq_full) && found;

  assign sel_lit = eng_lit[gidx*LIT_W +: LIT_W];
  assign sel_var = sel_lit[VAR_W-1:0];
  assign sel_pol = sel_lit[LIT_W-1];
  assign entry   = tbl_q[sel_var];

  assign eng_ready = grant ? (NUM_ENG'(1) << gidx) : '0;
  assign ucq_push  = grant && !entry[1];
  assign uca2ucq   = ucq_push ? sel_lit : '0;
  assign do_conf   = grant && entry[1] && (entry[0] != sel_pol);
  assign do_dup    = grant && entry[1] && (entry[0] == sel_pol);

  assign clr_start  = clear_req && (state_q != S_CLEAR);
  assign sweep_end  = (state_q == S_CLEAR) && (cnt_q == '1);
  assign clear_done = !rst && sweep_end;

  assign conflict     = conflict_q;
  assign conflict_lit = clit_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (clr_start)      state_d = S_CLEAR;
    else if (sweep_end) state_d = S_RUN;
    else if (do_conf)   state_d = S_CONFL;
    if (grant)
      rr_d = (gidx == IDX_W'(NUM_ENG - 1)) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      rr_q       <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
      clit_q     <= '0;
      for (int i = 0; i < TBL_D; i++) tbl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (clr_start) begin
        conflict_q <= 1'b0;
        cnt_q      <= '0;
      end else if (state_q == S_CLEAR) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (do_conf) begin
        conflict_q <= 1'b1;
        clit_q     <= sel_lit;
      end
      if (ucq_push) tbl_q[sel_var] <= {1'b1, sel_pol};
      if (state_q == S_CLEAR) tbl_q[cnt_q] <= '0;
    end
  end

`ifdef UCA_STATS_EN
  logic [31:0] sp_q, sd_q, sc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
      sd_q <= '0;
      sc_q <= '0;
    end else begin
      if (ucq_push && sp_q != '1) sp_q <= sp_q + 1'b1;
      if (do_dup && sd_q != '1)   sd_q <= sd_q + 1'b1;
      if (do_conf && sc_q != '1)  sc_q <= sc_q + 1'b1;
    end
  end

  assign stat_push = sp_q;
  assign stat_dup  = sd_q;
  assign stat_conf = sc_q;
`endif

endmodule
